// File: rtl/cpu_trace_buffer_pkg.sv
// Shared definitions for the multicycle-CPU trace recorder.
// FSM encoding and rd_data field layout helpers.
package cpu_trace_buffer_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_RUN   = 2'd2,
        S_HALT  = 2'd3
    } trace_fsm_t;

    localparam int FSM_W = 2;

    // Entry is {cycle, state, ir, mar}, MSB first.
    function automatic int off_mar();
        return 0;
    endfunction

    function automatic int off_ir(int addr_w);
        return addr_w;
    endfunction

    function automatic int off_state(int addr_w, int data_w);
        return addr_w + data_w;
    endfunction

    function automatic int off_cyc(int addr_w, int data_w, int state_w);
        return addr_w + data_w + state_w;
    endfunction

endpackage

// File: rtl/cpu_trace_buffer_ram.sv
// Simple dual-port entry store for the trace recorder.
// Synchronous write, synchronous read-first read port.
module cpu_trace_buffer_ram
    import cpu_trace_buffer_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] wd,
    input  logic             re,
    input  logic [AW-1:0]    ra,
    output logic [WIDTH-1:0] rd
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wa] <= wd;
        end
    end

    // Same-address read and write returns the old word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd <= '0;
        end else if (re) begin
            rd <= mem[ra];
        end
    end

endmodule

// File: rtl/cpu_trace_buffer.sv
// Trace recorder for the multicycle MIPS datapath.
// Captures {cycle, state, ir, mar} into a ring buffer drained by rd_req.
module cpu_trace_buffer
    import cpu_trace_buffer_pkg::*;
#(
    parameter  int DATA_W  = 32,
    parameter  int ADDR_W  = 32,
    parameter  int STATE_W = 5,
    parameter  int CYC_W   = 16,
    parameter  int DEPTH   = 64,
    localparam int ENTRY_W = CYC_W + STATE_W + DATA_W + ADDR_W,
    localparam int PTR_W   = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               clear,
    input  logic               trig_en,
    input  logic [STATE_W-1:0] trig_state,
    input  logic               mode_wrap,
    input  logic               change_only,
    input  logic [STATE_W-1:0] cpu_state,
    input  logic [DATA_W-1:0]  cpu_ir,
    input  logic [ADDR_W-1:0]  cpu_mar,
    input  logic               rd_req,
    output logic               rd_valid,
    output logic [ENTRY_W-1:0] rd_data,
    output logic [PTR_W:0]     count,
    output logic               full,
    output logic               overflow,
    output logic [1:0]         fsm_state
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    trace_fsm_t         state_q;
    trace_fsm_t         state_d;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CYC_W-1:0]   cyc;
    logic [STATE_W-1:0] last_state;
    logic               last_valid;
    logic               is_full;
    logic               pop;
    logic               trig_hit;
    logic               want;
    logic               store;
    logic               drop;
    logic               wrap_over;
    logic               counting;

    assign is_full   = (count == FULL_CNT);
    assign full      = is_full;
    assign fsm_state = state_q;
    assign pop       = rd_req && (count != '0) && !clear;
    assign trig_hit  = (state_q == S_ARMED) && (cpu_state == trig_state);
    assign counting  = (state_q == S_ARMED) || (state_q == S_RUN);

    assign want = enable && !clear
                && ((state_q == S_RUN) || trig_hit)
                && (!change_only || !last_valid
                    || (cpu_state != last_state));

    // A same-cycle pop frees a slot first, so the write always lands.
    assign store     = want && (!is_full || pop || mode_wrap);
    assign drop      = want && is_full && !pop && !mode_wrap;
    assign wrap_over = want && is_full && !pop && mode_wrap;

    always_comb begin
        state_d = state_q;
        if (clear || (state_q == S_IDLE)) begin
            if (!enable) begin
                state_d = S_IDLE;
            end else if (trig_en) begin
                state_d = S_ARMED;
            end else begin
                state_d = S_RUN;
            end
        end else if (!enable) begin
            state_d = S_IDLE;
        end else if (drop) begin
            state_d = S_HALT;
        end else begin
            unique case (state_q)
                S_ARMED: if (trig_hit) state_d = S_RUN;
                S_HALT:  if (pop) state_d = S_RUN;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            cyc        <= '0;
            last_state <= '0;
            last_valid <= 1'b0;
            rd_valid   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (clear) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                count      <= '0;
                overflow   <= 1'b0;
                cyc        <= '0;
                last_valid <= 1'b0;
                rd_valid   <= 1'b0;
            end else begin
                rd_valid <= pop;
                if (store) begin
                    wr_ptr     <= wr_ptr + 1'b1;
                    last_state <= cpu_state;
                    last_valid <= 1'b1;
                end
                if (pop || wrap_over) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (store && !pop && !is_full) begin
                    count <= count + 1'b1;
                end else if (pop && !store) begin
                    count <= count - 1'b1;
                end
                if (drop || wrap_over) begin
                    overflow <= 1'b1;
                end
                if (counting && (cyc != '1)) begin
                    cyc <= cyc + 1'b1;
                end
            end
        end
    end

    cpu_trace_buffer_ram #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (store),
        .wa    (wr_ptr),
        .wd    ({cyc, cpu_state, cpu_ir, cpu_mar}),
        .re    (pop),
        .ra    (rd_ptr),
        .rd    (rd_data)
    );

endmodule
